// File: rtl/cpu_types_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_types_pkg
// Description : Shared CPU datapath types.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_types_pkg;
  typedef logic [31:0] word_t;
endpackage
`default_nettype wire

// File: rtl/stage_mem_if.sv
`default_nettype none
// ============================================================================
// Module      : stage_mem_if
// Description : Memory-stage bundle: execute results in, data-cache
//               handshake, forwarding and writeback outputs.
// Revision    : 1.0 - initial release
// ============================================================================
interface stage_mem_if;
  import cpu_types_pkg::*;

  // pipeline control and execute results
  logic       enable;
  logic       flush;
  word_t      aluOut_in;
  word_t      rdat2_in;
  word_t      npc_in;
  logic [4:0] regSel_in;
  logic       memRead_in;
  logic       memWrite_in;
  logic       memtoReg_in;
  logic       regWrite_in;
  logic       jal_in;
  logic       halt_in;

  // data cache
  logic       dhit;
  word_t      dmemload;
  logic       dmemREN;
  logic       dmemWEN;
  word_t      dmemaddr;
  word_t      dmemstore;

  // hazard, forwarding and writeback
  logic       stall_out;
  word_t      for_dat_mem_out;
  word_t      for_dat_wb_out;
  word_t      wdat_out;
  logic [4:0] regSel_out;
  logic       regWrite_out;
  logic       halt_out;

  modport slave (
    input  enable, flush, aluOut_in, rdat2_in, npc_in, regSel_in,
           memRead_in, memWrite_in, memtoReg_in, regWrite_in, jal_in, halt_in,
           dhit, dmemload,
    output dmemREN, dmemWEN, dmemaddr, dmemstore, stall_out,
           for_dat_mem_out, for_dat_wb_out, wdat_out, regSel_out,
           regWrite_out, halt_out
  );

  modport master (
    output enable, flush, aluOut_in, rdat2_in, npc_in, regSel_in,
           memRead_in, memWrite_in, memtoReg_in, regWrite_in, jal_in, halt_in,
           dhit, dmemload,
    input  dmemREN, dmemWEN, dmemaddr, dmemstore, stall_out,
           for_dat_mem_out, for_dat_wb_out, wdat_out, regSel_out,
           regWrite_out, halt_out
  );
endinterface
`default_nettype wire

// File: rtl/stage_mem.sv
`default_nettype none
// ============================================================================
// Module      : stage_mem
// Description : Pipeline memory stage. Holds the EX/MEM (M) and MEM/WB (W)
//               registers and sequences one data-cache access per M entry.
// Revision    : 1.0 - initial release
// ============================================================================
module stage_mem
  import cpu_types_pkg::*;
(
  input  wire logic    clk,
  input  wire logic    rst,
  stage_mem_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2,
    HALT = 2'd3
  } state_t;

  typedef struct packed {
    word_t      alu_out;
    word_t      rdat2;
    word_t      npc;
    logic [4:0] reg_sel;
    logic       mem_read;
    logic       mem_write;
    logic       memto_reg;
    logic       reg_write;
    logic       jal;
    logic       halt;
  } ex_mem_t;

  typedef struct packed {
    word_t      wdat;
    logic [4:0] reg_sel;
    logic       reg_write;
    logic       halt;
  } mem_wb_t;

  state_t  state_q, state_d;
  ex_mem_t m_q, m_d;
  mem_wb_t w_q, w_d;
  word_t   load_q, load_d;

  ex_mem_t w_m_in;
  logic    w_stall;
  logic    w_adv;
  word_t   w_memval;
  word_t   w_wdat;

  assign w_m_in = '{
    alu_out:   bus.aluOut_in,
    rdat2:     bus.rdat2_in,
    npc:       bus.npc_in,
    reg_sel:   bus.regSel_in,
    mem_read:  bus.memRead_in,
    mem_write: bus.memWrite_in,
    memto_reg: bus.memtoReg_in,
    reg_write: bus.regWrite_in,
    jal:       bus.jal_in,
    halt:      bus.halt_in
  };

  // stall only while an access is outstanding and the cache has not answered
  assign w_stall  = (state_q == REQ) & ~bus.dhit;
  assign w_adv    = bus.enable & ~w_stall & (state_q != HALT);
  // once parked in DONE the cache may have moved on, so use the latched word
  assign w_memval = (state_q == DONE) ? load_q : bus.dmemload;
  assign w_wdat   = m_q.jal ? m_q.npc : (m_q.memto_reg ? w_memval : m_q.alu_out);

  // next-state, M/W/load register updates
  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    w_d     = w_q;
    load_d  = load_q;
    if (w_adv) begin
      m_d = bus.flush ? '0 : w_m_in;
      w_d = '{wdat: w_wdat, reg_sel: m_q.reg_sel,
              reg_write: m_q.reg_write, halt: m_q.halt};
      if (m_q.halt)
        state_d = HALT;
      else if ((bus.memRead_in | bus.memWrite_in) & ~bus.flush)
        state_d = REQ;
      else
        state_d = IDLE;
    end else begin
      // a stalled cycle retires nothing: W becomes a bubble so the
      // instruction ahead is not written back a second time
      if (w_stall)
        w_d = '0;
      // answered but not allowed to advance: park in DONE with the data
      if ((state_q == REQ) && bus.dhit) begin
        state_d = DONE;
        if (m_q.mem_read)
          load_d = bus.dmemload;
      end
    end
  end

  // state and pipeline registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      m_q     <= '0;
      w_q     <= '0;
      load_q  <= '0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      w_q     <= w_d;
      load_q  <= load_d;
    end
  end

  // requests depend on the (asynchronously cleared) state, so reset drops them at once
  assign bus.dmemREN         = (state_q == REQ) & m_q.mem_read & ~m_q.mem_write;
  assign bus.dmemWEN         = (state_q == REQ) & m_q.mem_write;
  assign bus.dmemaddr        = m_q.alu_out;
  assign bus.dmemstore       = m_q.rdat2;
  assign bus.stall_out       = w_stall;
  assign bus.for_dat_mem_out = m_q.jal ? m_q.npc : m_q.alu_out;
  assign bus.for_dat_wb_out  = w_q.wdat;
  assign bus.wdat_out        = w_q.wdat;
  assign bus.regSel_out      = w_q.reg_sel;
  assign bus.regWrite_out    = w_q.reg_write;
  assign bus.halt_out        = w_q.halt;

endmodule
`default_nettype wire

// File: tb/tb_stage_mem.sv
`default_nettype none
// ============================================================================
// Module      : tb_stage_mem
// Description : Self-checking bench for stage_mem: vector table, directed
//               multi-cycle sequences and randomized run against a
//               transaction-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stage_mem;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  stage_mem_if bus ();
  stage_mem dut (.clk(clk), .rst(rst), .bus(bus.slave));

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic [31:0] alu;
    logic [31:0] npc;
    logic [4:0]  rs;
    logic        rw;
    logic        jal;
    logic [31:0] exp_val;
  } vec_t;

  // transaction-level model state
  typedef struct {
    logic [31:0] alu, rdat2, npc;
    logic [4:0]  rs;
    logic        rd, wr, m2r, rw, jal, hlt;
  } instr_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h required 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] alu, input logic [31:0] rdat2, input logic [31:0] npc,
                       input logic [4:0] rs, input logic rd, input logic wr, input logic m2r,
                       input logic rw, input logic jal, input logic hlt);
    bus.enable      = 1'b1;
    bus.flush       = 1'b0;
    bus.aluOut_in   = alu;
    bus.rdat2_in    = rdat2;
    bus.npc_in      = npc;
    bus.regSel_in   = rs;
    bus.memRead_in  = rd;
    bus.memWrite_in = wr;
    bus.memtoReg_in = m2r;
    bus.regWrite_in = rw;
    bus.jal_in      = jal;
    bus.halt_in     = hlt;
  endtask

  task automatic nop();
    issue(32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic reset_pulse();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t        tbl[5];
    instr_t      mm, ci;
    logic        pending, got, halted, w_known, w_rw, w_h;
    logic [31:0] gdata, w_wdat, memval, wd;
    logic [4:0]  w_rs;
    logic        stall, adv, dhit_s;
    logic [31:0] dload_s;
    logic        en_s, fl_s;
    int          halt_cyc;

    // ---------------- reset state ----------------
    rst = 1'b1;
    bus.dhit = 1'b0;
    bus.dmemload = 32'h0;
    issue(32'h1234, 32'h5678, 32'h9ABC, 5'd3, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    tick(); tick(); tick();
    chk("rst_dmemREN",  {31'b0, bus.dmemREN},      32'h0);
    chk("rst_dmemWEN",  {31'b0, bus.dmemWEN},      32'h0);
    chk("rst_stall",    {31'b0, bus.stall_out},    32'h0);
    chk("rst_regWrite", {31'b0, bus.regWrite_out}, 32'h0);
    chk("rst_halt",     {31'b0, bus.halt_out},     32'h0);
    chk("rst_wdat",     bus.wdat_out,              32'h0);
    chk("rst_regSel",   {27'b0, bus.regSel_out},   32'h0);
    nop();
    rst = 1'b0;
    tick();

    // ---------------- ALU / JAL vector table ----------------
    tbl[0] = '{32'h0000_0010, 32'h0000_0004, 5'd5,  1'b1, 1'b0, 32'h0000_0010};
    tbl[1] = '{32'hFFFF_FFFF, 32'h0000_0008, 5'd31, 1'b1, 1'b0, 32'hFFFF_FFFF};
    tbl[2] = '{32'h0000_1234, 32'h0000_0044, 5'd31, 1'b1, 1'b1, 32'h0000_0044};
    tbl[3] = '{32'h0000_ABCD, 32'h0000_0080, 5'd0,  1'b0, 1'b0, 32'h0000_ABCD};
    tbl[4] = '{32'h0000_0000, 32'hFFFF_FFFC, 5'd1,  1'b1, 1'b1, 32'hFFFF_FFFC};
    for (int i = 0; i < 5; i++) begin
      issue(tbl[i].alu, 32'h0, tbl[i].npc, tbl[i].rs, 1'b0, 1'b0, 1'b0, tbl[i].rw, tbl[i].jal, 1'b0);
      tick();
      nop();
      #2;
      chk($sformatf("vec%0d_fwd_mem", i), bus.for_dat_mem_out, tbl[i].exp_val);
      tick();
      chk($sformatf("vec%0d_wdat", i),     bus.wdat_out,                tbl[i].exp_val);
      chk($sformatf("vec%0d_fwd_wb", i),   bus.for_dat_wb_out,          tbl[i].exp_val);
      chk($sformatf("vec%0d_regSel", i),   {27'b0, bus.regSel_out},     {27'b0, tbl[i].rs});
      chk($sformatf("vec%0d_regWrite", i), {31'b0, bus.regWrite_out},   {31'b0, tbl[i].rw});
    end

    // ---------------- load, dhit after 3 stalled cycles ----------------
    issue(32'h100, 32'h0, 32'h104, 5'd7, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    bus.dmemload = 32'h0000_DEAD;
    tick();
    nop();
    for (int i = 0; i < 3; i++) begin
      #2;
      chk("ld_dmemREN", {31'b0, bus.dmemREN},   32'h1);
      chk("ld_stall",   {31'b0, bus.stall_out}, 32'h1);
      chk("ld_addr",    bus.dmemaddr,           32'h100);
      tick();
      chk("ld_bubble",  {31'b0, bus.regWrite_out}, 32'h0);
    end
    // dhit arrives together with a store waiting in execute
    issue(32'h200, 32'hCAFE, 32'h0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    bus.dhit = 1'b1;
    #2;
    chk("ld_hit_stall", {31'b0, bus.stall_out}, 32'h0);
    tick();
    bus.dhit = 1'b0;
    chk("ld_wdat",     bus.wdat_out,              32'h0000_DEAD);
    chk("ld_regWrite", {31'b0, bus.regWrite_out}, 32'h1);
    chk("ld_regSel",   {27'b0, bus.regSel_out},   32'd7);

    // ---------------- store answered while enable=0 ----------------
    nop();
    bus.enable = 1'b0;
    bus.dhit   = 1'b1;
    #2;
    chk("st_dmemWEN", {31'b0, bus.dmemWEN}, 32'h1);
    chk("st_dmemREN", {31'b0, bus.dmemREN}, 32'h0);
    chk("st_store",   bus.dmemstore,        32'hCAFE);
    chk("st_addr",    bus.dmemaddr,         32'h200);
    tick();
    bus.dhit = 1'b0;
    #2;
    chk("st_done_WEN",   {31'b0, bus.dmemWEN},   32'h0);
    chk("st_done_stall", {31'b0, bus.stall_out}, 32'h0);
    chk("st_w_hold",     bus.wdat_out,           32'h0000_DEAD);
    tick();
    chk("st_w_hold2",    bus.wdat_out,           32'h0000_DEAD);
    // release, with a load following the store
    issue(32'h300, 32'h0, 32'h0, 5'd9, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    chk("st_wdat",     bus.wdat_out,              32'h200);
    chk("st_regWrite", {31'b0, bus.regWrite_out}, 32'h0);

    // ---------------- load parked in DONE keeps the hit data ----------------
    nop();
    bus.enable   = 1'b0;
    bus.dhit     = 1'b1;
    bus.dmemload = 32'h1234_5678;
    tick();
    bus.dhit     = 1'b0;
    bus.dmemload = 32'hFFFF_0000;
    tick();
    chk("ldd_w_hold", bus.wdat_out,           32'h200);
    chk("ldd_REN",    {31'b0, bus.dmemREN},   32'h0);
    bus.enable = 1'b1;
    tick();
    chk("ldd_wdat",     bus.wdat_out,              32'h1234_5678);
    chk("ldd_regSel",   {27'b0, bus.regSel_out},   32'd9);
    chk("ldd_regWrite", {31'b0, bus.regWrite_out}, 32'h1);

    // ---------------- flush on advance cancels a store ----------------
    issue(32'h400, 32'h55, 32'h0, 5'd3, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    bus.flush = 1'b1;
    tick();
    nop();
    #2;
    chk("fl_WEN",   {31'b0, bus.dmemWEN},   32'h0);
    chk("fl_stall", {31'b0, bus.stall_out}, 32'h0);
    tick();
    chk("fl_regWrite", {31'b0, bus.regWrite_out}, 32'h0);

    // ---------------- flush while stalled is deferred ----------------
    issue(32'h500, 32'h0, 32'h0, 5'd4, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    bus.dmemload = 32'h0BAD_F00D;
    tick();
    nop();
    bus.flush = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #2;
      chk("fs_stall", {31'b0, bus.stall_out}, 32'h1);
      chk("fs_REN",   {31'b0, bus.dmemREN},   32'h1);
      tick();
    end
    bus.dhit = 1'b1;
    tick();
    bus.dhit  = 1'b0;
    bus.flush = 1'b0;
    chk("fs_wdat",     bus.wdat_out,              32'h0BAD_F00D);
    chk("fs_regWrite", {31'b0, bus.regWrite_out}, 32'h1);
    #2;
    chk("fs_REN_after", {31'b0, bus.dmemREN}, 32'h0);

    // ---------------- reset during an outstanding access ----------------
    tick();
    issue(32'h600, 32'h0, 32'h0, 5'd2, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    nop();
    #2;
    chk("ra_REN_before", {31'b0, bus.dmemREN}, 32'h1);
    rst = 1'b1;
    #1;
    chk("ra_REN_async", {31'b0, bus.dmemREN}, 32'h0);
    tick();
    rst = 1'b0;
    #2;
    chk("ra_REN_idle",   {31'b0, bus.dmemREN},   32'h0);
    chk("ra_stall_idle", {31'b0, bus.stall_out}, 32'h0);

    // ---------------- halt is sticky until reset ----------------
    tick();
    issue(32'h700, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    nop();
    #2;
    chk("h_halt_early", {31'b0, bus.halt_out}, 32'h0);
    tick();
    chk("h_halt", {31'b0, bus.halt_out}, 32'h1);
    for (int i = 0; i < 6; i++) begin
      issue(32'h800 + i, 32'h0, 32'h0, 5'd1, 1'b1, i[1], 1'b1, 1'b1, 1'b0, 1'b0);
      bus.enable = i[0];
      tick();
      chk("h_sticky", {31'b0, bus.halt_out}, 32'h1);
      chk("h_noreq",  {30'b0, bus.dmemREN, bus.dmemWEN}, 32'h0);
    end
    rst = 1'b1;
    #2;
    chk("h_rst_clear", {31'b0, bus.halt_out}, 32'h0);
    tick();
    rst = 1'b0;
    nop();

    // ---------------- randomized run against the reference model ----------------
    mm = '{default: '0};
    pending = 0; got = 0; halted = 0; gdata = 0;
    w_wdat = 0; w_rs = 0; w_rw = 0; w_h = 0; w_known = 1;
    halt_cyc = 0;
    for (int cyc = 0; cyc < 800; cyc++) begin
      if (halted) begin
        halt_cyc++;
        if (halt_cyc >= 4) begin
          reset_pulse();
          mm = '{default: '0};
          pending = 0; got = 0; halted = 0; gdata = 0;
          w_wdat = 0; w_rs = 0; w_rw = 0; w_h = 0; w_known = 1;
          halt_cyc = 0;
        end
      end
      ci.alu   = $urandom;
      ci.rdat2 = $urandom;
      ci.npc   = $urandom;
      ci.rs    = 5'($urandom);
      ci.rd    = ($urandom_range(0, 2) == 0);
      ci.wr    = ($urandom_range(0, 3) == 0);
      ci.m2r   = ci.rd & $urandom_range(0, 1);
      ci.rw    = $urandom_range(0, 1);
      ci.jal   = ($urandom_range(0, 7) == 0);
      ci.hlt   = ($urandom_range(0, 49) == 0);
      issue(ci.alu, ci.rdat2, ci.npc, ci.rs, ci.rd, ci.wr, ci.m2r, ci.rw, ci.jal, ci.hlt);
      en_s    = ($urandom_range(0, 3) != 0);
      fl_s    = ($urandom_range(0, 7) == 0);
      dhit_s  = ($urandom_range(0, 2) == 0);
      dload_s = $urandom;
      bus.enable   = en_s;
      bus.flush    = fl_s;
      bus.dhit     = dhit_s;
      bus.dmemload = dload_s;
      #2;
      // what the stage should present this cycle
      stall  = pending & ~dhit_s;
      adv    = en_s & ~stall & ~halted;
      memval = got ? gdata : dload_s;
      wd     = mm.jal ? mm.npc : (mm.m2r ? memval : mm.alu);
      chk("rnd_stall",    {31'b0, bus.stall_out},    {31'b0, stall});
      chk("rnd_REN",      {31'b0, bus.dmemREN},      {31'b0, pending & mm.rd & ~mm.wr});
      chk("rnd_WEN",      {31'b0, bus.dmemWEN},      {31'b0, pending & mm.wr});
      chk("rnd_addr",     bus.dmemaddr,              mm.alu);
      chk("rnd_fwd_mem",  bus.for_dat_mem_out,       mm.jal ? mm.npc : mm.alu);
      chk("rnd_halt",     {31'b0, bus.halt_out},     {31'b0, w_h});
      chk("rnd_regWrite", {31'b0, bus.regWrite_out}, {31'b0, w_rw});
      if (w_known) begin
        chk("rnd_wdat",   bus.wdat_out,              w_wdat);
        chk("rnd_regSel", {27'b0, bus.regSel_out},   {27'b0, w_rs});
      end
      @(posedge clk);
      // advance the model by one clock
      if (adv) begin
        w_wdat = wd; w_rs = mm.rs; w_rw = mm.rw; w_h = mm.hlt; w_known = 1;
        if (mm.hlt) halted = 1;
        mm      = fl_s ? '{default: '0} : ci;
        pending = ~halted & (ci.rd | ci.wr) & ~fl_s;
        got     = 0;
      end else if (stall) begin
        w_rw = 0; w_h = 0; w_known = 0;
      end else if (pending && dhit_s) begin
        pending = 0;
        got     = 1;
        gdata   = dload_s;
      end
      #1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/stage_mem.md
STAGE_MEM -- requirements
Module: stage_mem

Interface
- REQ-001 Parameters: none; word_t SHALL be 32 bits, from cpu_types_pkg.
- REQ-002 Clocking SHALL be one clock; reset is asynchronous and active-high.
- REQ-003 CLK  in  1  rising-edge clock.
- REQ-004 RST  in  1  asynchronous active-high reset.
- REQ-005 enable  in  1  pipeline advance permission from the hazard unit.
- REQ-006 flush  in  1  inserts a bubble into the EX/MEM register on advance.
- REQ-007 aluOut_in, rdat2_in, npc_in  in  32 each  execute results: address/ALU value, store data, PC+4.
- REQ-008 regSel_in  in  5  destination register.
- REQ-009 memRead_in, memWrite_in, memtoReg_in, regWrite_in, jal_in, halt_in  in  1 each  execute control.
- REQ-010 dhit  in  1  data cache completion.
- REQ-011 dmemload  in  32  data cache read data.
- REQ-012 dmemREN, dmemWEN  out  1 each  data cache requests.
- REQ-013 dmemaddr, dmemstore  out  32 each  data cache address and store data.
- REQ-014 stall_out  out  1  memory-stage stall request.
- REQ-015 for_dat_mem_out, for_dat_wb_out  out  32 each  forwarding values for execute.
- REQ-016 wdat_out  out  32  writeback data.
- REQ-017 regSel_out  out  5  writeback register select.
- REQ-018 regWrite_out, halt_out  out  1 each  writeback controls.

Function
- REQ-019 The block SHALL hold an EX/MEM register set (M) and a MEM/WB register set (W).
- REQ-020 State SHALL be one of IDLE, REQ, DONE, HALT.
- REQ-021 adv SHALL equal enable & ~stall_out & (state != HALT).
- REQ-022 stall_out SHALL equal (state == REQ) & ~dhit, combinationally.
- REQ-023 On adv with flush=0, M SHALL capture all *_in values.
- REQ-024 On adv with flush=1, M SHALL clear to zero.
- REQ-025 Without adv, M SHALL hold.
- REQ-026 Next state on adv SHALL be REQ if (memRead_in | memWrite_in) & ~flush, else IDLE.
- REQ-027 Without adv, REQ & dhit SHALL go to DONE.
- REQ-028 In DONE, the block SHALL capture dmemload into load_r if memRead_M.
- REQ-029 DONE SHALL hold until adv.
- REQ-030 dmemREN SHALL equal (state == REQ) & memRead_M & ~memWrite_M.
- REQ-031 dmemWEN SHALL equal (state == REQ) & memWrite_M; write wins if both are set.
- REQ-032 dmemaddr SHALL equal aluOut_M and dmemstore SHALL equal rdat2_M, combinationally.
- REQ-033 memval SHALL be load_r in DONE, else dmemload.
- REQ-034 On adv, W SHALL load wdat = jal_M ? npc_M : memtoReg_M ? memval : aluOut_M, together with regSel_M, regWrite_M and halt_M.
- REQ-035 Load-use latency: data SHALL appear on wdat_out one cycle after the dhit cycle when enable=1.
- REQ-036 When stall_out=1, W SHALL load a bubble (regWrite=0, halt=0) so that no register is written twice.
- REQ-037 When enable=0 and stall_out=0, W SHALL hold.
- REQ-038 for_dat_mem_out SHALL equal jal_M ? npc_M : aluOut_M.
- REQ-039 for_dat_wb_out SHALL equal wdat_out.
- REQ-040 When a halt is loaded into W, state SHALL go to HALT.
- REQ-041 HALT SHALL be sticky until RST: halt_out=1, no further advance, no cache requests.
- REQ-042 flush asserted while stalled in REQ SHALL be ignored until adv; the outstanding access SHALL complete.
- REQ-043 Simultaneous dhit and adv in REQ SHALL retire the access into W and load the next M in the same edge.

Reset
- REQ-044 While RST=1, all M, W and load_r registers SHALL be 0 and state SHALL be IDLE.
- REQ-045 While RST=1, all outputs SHALL be 0: dmemREN, dmemWEN, stall_out, regWrite_out, halt_out, wdat_out and regSel_out.
- REQ-046 RST asserted mid-access SHALL drop dmemREN and dmemWEN immediately (asynchronously).

Verification
- REQ-047 ALU op: aluOut_in=0x10, regSel_in=5, regWrite_in=1, enable=1 -> next cycle for_dat_mem_out=0x10; following cycle wdat_out=0x10, regSel_out=5, regWrite_out=1.
- REQ-048 Load with dhit delayed 3 cycles: aluOut_in=0x100, memRead=1, memtoReg=1, dmemload=0xDEAD -> dmemREN=1 and stall_out=1 for 3 cycles; bubble in W each stalled cycle; wdat_out=0xDEAD one cycle after dhit.
- REQ-049 Store, then enable=0 at dhit: dmemWEN=1, dmemstore=rdat2_in; state DONE with requests low; W holds until enable=1.
- REQ-050 flush=1 on advance with memWrite_in=1 -> no dmemWEN, state IDLE, regWrite_out=0.
- REQ-051 halt_in=1 -> halt_out=1 two cycles later and remains 1 with enable toggling; RST clears it to 0.
- REQ-052 RST asserted during REQ -> dmemREN=0 the same cycle; state IDLE after release.
